// File: rtl/deserializer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// deserializer_if : serial-in / parallel-out bundle for the link deserializer
// Revision 1.0
//------------------------------------------------------------------------------
interface deserializer_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
);
  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;

  // master feeds the serial line and observes the rebuilt word
  modport master (
    output ser_data_i, ser_data_val_i,
    input  deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o
  );

  modport slave (
    input  ser_data_i, ser_data_val_i,
    output deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// deserializer : MSB-first serial stream to left-aligned word plus (bits-1) length
// Revision 1.0
//------------------------------------------------------------------------------
module deserializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input  logic           clk_i,
  input  logic           srst_i,
  deserializer_if.slave  bus
);

  localparam int              CNT_W = MOD_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [CNT_W-1:0]    count_inc, count_m1, pos;
  logic [DATA_W-1:0]   with_bit;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [MOD_W-1:0]    mod_q, mod_nxt;
  logic                val_q, val_nxt;
  logic                busy_q, busy_nxt;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state  <= IDLE;
      shreg  <= '0;
      count  <= '0;
      data_q <= '0;
      mod_q  <= '0;
      val_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      count  <= count_nxt;
      data_q <= data_nxt;
      mod_q  <= mod_nxt;
      val_q  <= val_nxt;
      busy_q <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    count_nxt = count;
    data_nxt  = data_q;
    mod_nxt   = mod_q;
    val_nxt   = 1'b0;

    count_inc = count + CNT_W'(1);
    count_m1  = count - CNT_W'(1);
    pos       = TOP - count;
    with_bit  = shreg;
    with_bit[pos[MOD_W-1:0]] = bus.ser_data_i;

    // shreg is cleared at every frame end, so a new frame never inherits old LSBs
    if (bus.ser_data_val_i) begin
      if (count_inc == FULL) begin
        data_nxt  = with_bit;
        mod_nxt   = MOD_W'(DATA_W - 1);
        val_nxt   = 1'b1;
        shreg_nxt = '0;
        count_nxt = '0;
        state_nxt = IDLE;
      end else begin
        shreg_nxt = with_bit;
        count_nxt = count_inc;
        state_nxt = SHIFT;
      end
    end else if (state == SHIFT) begin
      data_nxt  = shreg;
      mod_nxt   = count_m1[MOD_W-1:0];
      val_nxt   = 1'b1;
      shreg_nxt = '0;
      count_nxt = '0;
      state_nxt = IDLE;
    end

    busy_nxt = (count_nxt != '0);
  end

  assign bus.deser_data_o     = data_q;
  assign bus.deser_data_mod_o = mod_q;
  assign bus.deser_data_val_o = val_q;
  assign bus.busy_o           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_deserializer : scoreboard bench, directed cases plus random serializer frames
// Revision 1.0
//------------------------------------------------------------------------------
module tb_deserializer;

  logic clk = 1'b0;
  logic srst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    int          due;
  } exp_t;

  exp_t sb[$];

  deserializer_if #(.DATA_W(16), .MOD_W(4)) bus ();

  deserializer #(.DATA_W(16), .MOD_W(4)) dut (
    .clk_i (clk),
    .srst_i(srst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock with the given serial inputs; returns just after the edge
  task automatic step(input logic v, input logic b);
    bus.ser_data_val_i = v;
    bus.ser_data_i     = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] top_bits(input logic [15:0] word, input int nbits);
    logic [15:0] ones;
    ones = 16'hFFFF;
    return word & ~(ones >> nbits);
  endfunction

  // serializer model: sends the top nbits of word MSB first, then gap idle cycles
  task automatic send_frame(input logic [15:0] word, input int nbits, input int gap);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      step(1'b1, word[15-i]);
      if (nbits == 16 && i == 15) begin
        e.data = word;
        e.mod  = 4'd15;
        e.due  = cyc;
        sb.push_back(e);
        check("busy_after_full", {31'd0, bus.busy_o}, 32'd0);
      end else begin
        check("busy_in_frame", {31'd0, bus.busy_o}, 32'd1);
      end
    end
    if (nbits < 16) begin
      step(1'b0, 1'($urandom));
      e.data = top_bits(word, nbits);
      e.mod  = 4'(nbits - 1);
      e.due  = cyc;
      sb.push_back(e);
      check("busy_after_short", {31'd0, bus.busy_o}, 32'd0);
    end
    for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom));
  endtask

  // monitor: every strobe must match the oldest expected word, on its due cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.deser_data_val_o === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got data=%0h mod=%0d expected no strobe (cycle %0d)",
                   bus.deser_data_o, bus.deser_data_mod_o, cyc);
        end else begin
          e = sb.pop_front();
          check("data", {16'd0, bus.deser_data_o}, {16'd0, e.data});
          check("mod", {28'd0, bus.deser_data_mod_o}, {28'd0, e.mod});
          check("strobe_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          n;

    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    check("rst_data", {16'd0, bus.deser_data_o}, 32'd0);
    check("rst_mod", {28'd0, bus.deser_data_mod_o}, 32'd0);
    check("rst_val", {31'd0, bus.deser_data_val_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);

    send_frame(16'hA5C3, 16, 2);
    send_frame(16'hB000, 5, 1);
    send_frame(16'h8000, 1, 1);
    send_frame(16'hFFFF, 16, 0);
    send_frame(16'h4000, 3, 2);

    // abort a partial frame with reset; no strobe may appear for it
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom));
    srst = 1'b1;
    step(1'b0, 1'b0);
    srst = 1'b0;
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("midrst_val", {31'd0, bus.deser_data_val_o}, 32'd0);
    check("midrst_data", {16'd0, bus.deser_data_o}, 32'd0);
    send_frame(16'hC000, 2, 2);

    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'($urandom));
      check("idle_busy", {31'd0, bus.busy_o}, 32'd0);
    end

    for (int f = 0; f < 10; f++) begin
      w = 16'($urandom);
      n = int'($urandom_range(0, 15)) + 1;
      send_frame(w, n, int'($urandom_range(0, 3)));
    end
    step(1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
